fetchbuffer: RTL

//   Responder side of the fetch_stage <-> fetchbuffer mem_in_type/mem_out_type link.

---
 rtl/fetchbuffer_pkg.sv | 22 ++
 rtl/fetchbuffer_if.sv | 10 +
 rtl/fetchbuffer_ram.sv | 34 +++
 rtl/fetchbuffer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fetchbuffer_pkg.sv
// Shared types and constants for the fetch buffer and its two memory-style links.
package fetchbuffer_pkg;

  localparam int          fetchbuffer_depth = 8;
  localparam logic [31:0] nop_instr         = 32'h0000_0013;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/fetchbuffer_if.sv
// Request/response link: master drives req and consumes rsp, slave the reverse.
interface fetchbuffer_if;
  import fetchbuffer_pkg::*;

  mem_in_type  req;
  mem_out_type rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/fetchbuffer_ram.sv
// Halfword storage for the fetch buffer: two write ports, head and head+1 read ports.
module fetchbuffer_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wen0,
  input  logic [AW-1:0] waddr0,
  input  logic [15:0]   wdata0,
  input  logic          wen1,
  input  logic [AW-1:0] waddr1,
  input  logic [15:0]   wdata1,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata0,
  output logic [15:0]   rdata1
);

  logic [15:0] ram_q [DEPTH];
  logic [15:0] ram_d [DEPTH];

  always_comb begin
    ram_d = ram_q;
    if (wen0) ram_d[waddr0] = wdata0;
    if (wen1) ram_d[waddr1] = wdata1;
  end

  always_ff @(posedge clock) begin
    ram_q <= ram_d;
  end

  assign rdata0 = ram_q[raddr];
  assign rdata1 = ram_q[raddr + AW'(1)];

endmodule

// File: rtl/fetchbuffer.sv
// Prefetching instruction buffer: word fetches from imem, halfword FIFO, one
// (possibly compressed) instruction handed to fetch per accepted request.
module fetchbuffer
  import fetchbuffer_pkg::*;
#(
  parameter int DEPTH = fetchbuffer_depth
) (
  input  logic          clock,
  input  logic          reset,
  fetchbuffer_if.slave  fetch,
  fetchbuffer_if.master imem
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] idx_t;

  typedef struct packed {
    ptr_t        wptr;
    ptr_t        rptr;
    logic [31:0] head_pc;
    logic [31:0] fetch_addr;
    logic [31:0] req_addr;
    logic        pend;
    logic        discard;
    logic        align;
  } fetchbuffer_reg_type;

  localparam fetchbuffer_reg_type init_fetchbuffer_reg = '0;

  fetchbuffer_reg_type r_q, r_d;

  ptr_t        count, need;
  logic [15:0] h0, h1;
  logic        flush, need2, fb_ready, rsp, issue;
  logic        wen0, wen1;
  idx_t        waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic        unused_fetch;

  fetchbuffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock  (clock),
    .wen0   (wen0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .wen1   (wen1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .raddr  (r_q.rptr[AW-1:0]),
    .rdata0 (h0),
    .rdata1 (h1)
  );

  assign unused_fetch = ^{fetch.req.mem_instr, fetch.req.mem_wdata, fetch.req.mem_wstrb};

  assign count    = r_q.wptr - r_q.rptr;
  assign need2    = (h0[1:0] == 2'b11);
  assign need     = need2 ? ptr_t'(2) : ptr_t'(1);
  assign flush    = fetch.req.mem_valid & (fetch.req.mem_spec | fetch.req.mem_fence);
  assign fb_ready = fetch.req.mem_valid & ~flush & (count >= need)
                    & (fetch.req.mem_addr == r_q.head_pc);
  assign rsp      = r_q.pend & imem.rsp.mem_ready;
  // Two free slots at issue time guarantee room for the whole word on return.
  assign issue    = ~r_q.pend & ~flush & (count <= ptr_t'(DEPTH - 2));

  always_comb begin
    fetch.rsp           = '0;
    fetch.rsp.mem_ready = fb_ready;
    fetch.rsp.mem_rdata = nop_instr;
    if (fb_ready) fetch.rsp.mem_rdata = need2 ? {h1, h0} : {16'h0, h0};
  end

  always_comb begin
    imem.req           = '0;
    imem.req.mem_valid = r_q.pend;
    imem.req.mem_instr = 1'b1;
    imem.req.mem_addr  = r_q.req_addr;
  end

  always_comb begin
    r_d    = r_q;
    wen0   = 1'b0;
    wen1   = 1'b0;
    waddr0 = r_q.wptr[AW-1:0];
    waddr1 = r_q.wptr[AW-1:0] + idx_t'(1);
    wdata0 = imem.rsp.mem_rdata[15:0];
    wdata1 = imem.rsp.mem_rdata[31:16];

    if (fb_ready) begin
      r_d.rptr    = r_q.rptr + need;
      r_d.head_pc = r_q.head_pc + (32'(need) << 1);
    end

    if (rsp) begin
      r_d.pend = 1'b0;
      if (r_q.discard) begin
        r_d.discard = 1'b0;
      end else begin
        r_d.fetch_addr = r_q.fetch_addr + 32'd4;
        r_d.align      = 1'b0;
        wen0           = 1'b1;
        if (r_q.align) begin
          wdata0   = imem.rsp.mem_rdata[31:16];
          r_d.wptr = r_q.wptr + ptr_t'(1);
        end else begin
          wen1     = 1'b1;
          r_d.wptr = r_q.wptr + ptr_t'(2);
        end
      end
    end

    if (issue) begin
      r_d.pend     = 1'b1;
      r_d.req_addr = r_q.fetch_addr;
    end

    // A redirect beats a same-cycle response; an in-flight request is left to finish and dropped.
    if (flush) begin
      wen0           = 1'b0;
      wen1           = 1'b0;
      r_d.wptr       = '0;
      r_d.rptr       = '0;
      r_d.head_pc    = fetch.req.mem_addr;
      r_d.fetch_addr = {fetch.req.mem_addr[31:2], 2'b00};
      r_d.align      = fetch.req.mem_addr[1];
      r_d.discard    = r_q.pend & ~imem.rsp.mem_ready;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_q <= init_fetchbuffer_reg;
    else       r_q <= r_d;
  end

endmodule
